// File: rtl/pong_pkg.sv
// Shared ping-pong definitions: game state, field/ball/paddle geometry and the
// coordinate type used by the ball engine, renderer and paddle controller.
package pong_pkg;

  // Screen coordinate, unsigned pixels.
  typedef logic [9:0] coord_t;

  // Ball engine states.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StMove   = 2'd1,
    StMissed = 2'd2
  } state_e;

  // Default geometry.
  localparam int unsigned HMaxDef       = 640;
  localparam int unsigned VMaxDef       = 480;
  localparam int unsigned BallSizeDef   = 8;
  localparam int unsigned PaddleXDef    = 16;
  localparam int unsigned PaddleWDef    = 8;
  localparam int unsigned PaddleHDef    = 64;
  localparam int unsigned StepDef       = 2;
  localparam int unsigned HoldFramesDef = 60;

endpackage

// File: rtl/frame_hold_timer.sv
// Post-miss hold timer: after start, counts HOLD_FRAMES frame ticks and then
// emits a one-cycle done pulse in the cycle of the last counted tick.
module frame_hold_timer #(
  parameter int unsigned HOLD_FRAMES = 60
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic frame_tick,
  output logic done
);

  localparam int unsigned CntW = $clog2(HOLD_FRAMES + 1);

  logic            r_active;
  logic [CntW-1:0] r_cnt;
  logic            w_last;

  assign w_last = (r_cnt == CntW'(HOLD_FRAMES - 1));
  // A tick coinciding with start belongs to the miss frame and is not counted.
  assign done   = r_active && frame_tick && !start && w_last;

  // Tick counter, armed by start and disarmed when the hold period ends.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
    end else if (start) begin
      r_active <= 1'b1;
      r_cnt    <= '0;
    end else if (r_active && frame_tick) begin
      if (w_last) begin
        r_active <= 1'b0;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ball_motion.sv
// Ball position and bounce engine. Once per frame tick it advances the ball,
// reflects it off the top/bottom/right walls and the left paddle, and pulses
// miss when the ball leaves the field on the left.
// Optional feature: define BALL_SPEEDUP_EN to raise the step by one every
// four paddle hits (capped at STEP+2).
module ball_motion
  import pong_pkg::*;
#(
  parameter int unsigned H_MAX       = HMaxDef,
  parameter int unsigned V_MAX       = VMaxDef,
  parameter int unsigned BALL_SIZE   = BallSizeDef,
  parameter int unsigned PADDLE_X    = PaddleXDef,
  parameter int unsigned PADDLE_W    = PaddleWDef,
  parameter int unsigned PADDLE_H    = PaddleHDef,
  parameter int unsigned STEP        = StepDef,
  parameter int unsigned HOLD_FRAMES = HoldFramesDef
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       serve,
  input  logic [9:0] paddle_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       miss,
  output logic       hit,
  output logic       playing
);

  localparam coord_t XCenter = coord_t'(H_MAX / 2 - BALL_SIZE / 2);
  localparam coord_t YCenter = coord_t'(V_MAX / 2 - BALL_SIZE / 2);
  localparam coord_t XMax    = coord_t'(H_MAX - BALL_SIZE);
  localparam coord_t YMax    = coord_t'(V_MAX - BALL_SIZE);
  localparam coord_t Face    = coord_t'(PADDLE_X + PADDLE_W);

  localparam logic signed [10:0] SXMax = 11'(H_MAX - BALL_SIZE);
  localparam logic signed [10:0] SYMax = 11'(V_MAX - BALL_SIZE);
  localparam logic signed [10:0] SFace = 11'(PADDLE_X + PADDLE_W);

  state_e r_state, w_state_d;
  coord_t r_x, w_x_d;
  coord_t r_y, w_y_d;
  logic   r_dx_neg, w_dx_neg_d;
  logic   r_dy_neg, w_dy_neg_d;
  logic   r_hit, w_hit_d;
  logic   r_miss, w_miss_d;

  logic signed [10:0] w_step;
  logic signed [10:0] w_nx;
  logic signed [10:0] w_ny;
  logic               w_overlap;
  logic               w_done;
  logic               w_enter_idle;

  // Candidate positions in 11-bit signed so nothing wraps below zero.
  assign w_nx = r_dx_neg ? $signed({1'b0, r_x}) - w_step : $signed({1'b0, r_x}) + w_step;
  assign w_ny = r_dy_neg ? $signed({1'b0, r_y}) - w_step : $signed({1'b0, r_y}) + w_step;

  // Vertical overlap with the paddle on the current y; 12 bits avoid overflow.
  assign w_overlap = (({2'b00, r_y} + 12'(BALL_SIZE)) > {2'b00, paddle_y}) &&
                     ({2'b00, r_y} < ({2'b00, paddle_y} + 12'(PADDLE_H)));

  assign w_enter_idle = (r_state != StIdle) && (w_state_d == StIdle);

  frame_hold_timer #(
    .HOLD_FRAMES (HOLD_FRAMES)
  ) u_hold (
    .clk        (clk),
    .reset      (reset),
    .start      (w_miss_d),
    .frame_tick (frame_tick),
    .done       (w_done)
  );

  // Next-state, position, direction and pulse logic.
  always_comb begin
    w_state_d  = r_state;
    w_x_d      = r_x;
    w_y_d      = r_y;
    w_dx_neg_d = r_dx_neg;
    w_dy_neg_d = r_dy_neg;
    w_hit_d    = 1'b0;
    w_miss_d   = 1'b0;
    unique case (r_state)
      StIdle: begin
        // Entering flight never moves the ball in the same cycle.
        if (serve) w_state_d = StMove;
      end
      StMove: begin
        if (frame_tick) begin
          if (r_dx_neg && (r_x >= Face) && (w_nx < SFace) && w_overlap) begin
            w_x_d      = Face;
            w_dx_neg_d = 1'b0;
            w_hit_d    = 1'b1;
          end else if (r_dx_neg && (w_nx < 11'sd0)) begin
            w_miss_d  = 1'b1;
            w_state_d = StMissed;
          end else if (!r_dx_neg && (w_nx >= SXMax)) begin
            w_x_d      = XMax;
            w_dx_neg_d = 1'b1;
          end else begin
            w_x_d = w_nx[9:0];
          end
          // Ball freezes entirely on a miss.
          if (!w_miss_d) begin
            if (w_ny <= 11'sd0) begin
              w_y_d      = '0;
              w_dy_neg_d = 1'b0;
            end else if (w_ny >= SYMax) begin
              w_y_d      = YMax;
              w_dy_neg_d = 1'b1;
            end else begin
              w_y_d = w_ny[9:0];
            end
          end
        end
      end
      StMissed: begin
        if (w_done) begin
          w_state_d  = StIdle;
          w_x_d      = XCenter;
          w_y_d      = YCenter;
          w_dx_neg_d = 1'b0;
          w_dy_neg_d = 1'b0;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State, position, direction and pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= StIdle;
      r_x      <= XCenter;
      r_y      <= YCenter;
      r_dx_neg <= 1'b0;
      r_dy_neg <= 1'b0;
      r_hit    <= 1'b0;
      r_miss   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_x      <= w_x_d;
      r_y      <= w_y_d;
      r_dx_neg <= w_dx_neg_d;
      r_dy_neg <= w_dy_neg_d;
      r_hit    <= w_hit_d;
      r_miss   <= w_miss_d;
    end
  end

`ifdef BALL_SPEEDUP_EN
  logic [1:0] r_hit_cnt;
  logic [3:0] r_step;

  // Hit counter; each wrap bumps the step until it reaches STEP+2.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hit_cnt <= '0;
      r_step    <= 4'(STEP);
    end else if (w_enter_idle) begin
      r_hit_cnt <= '0;
      r_step    <= 4'(STEP);
    end else if (w_hit_d) begin
      r_hit_cnt <= r_hit_cnt + 2'd1;
      if ((r_hit_cnt == 2'd3) && (r_step < 4'(STEP + 2))) r_step <= r_step + 4'd1;
    end
  end

  assign w_step = $signed(11'(r_step));
`else
  assign w_step = $signed(11'(STEP));
`endif

  assign ball_x  = r_x;
  assign ball_y  = r_y;
  assign hit     = r_hit;
  assign miss    = r_miss;
  assign playing = (r_state == StMove);

endmodule

// File: tb/tb_ball_motion.sv
// Self-checking bench for ball_motion: directed scenarios plus randomized
// play, all checked against a behavioural model of the game rules.
module tb_ball_motion;

  localparam int FACE = 24;
  localparam int XMAX = 632;
  localparam int YMAX = 472;
  localparam int XC   = 316;
  localparam int YC   = 236;
  localparam int STEP = 2;
  localparam int HOLD = 60;
`ifdef BALL_SPEEDUP_EN
  localparam int STEP_AFTER4 = 3;
`else
  localparam int STEP_AFTER4 = 2;
`endif

  logic       clk;
  logic       rst_n;
  logic       frame_tick;
  logic       serve;
  logic [9:0] paddle_y;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       miss;
  logic       hit;
  logic       playing;

  int total = 0;
  int bad   = 0;
  int lives = 3;

  // Model state: 0 idle, 1 in flight, 2 post-miss hold.
  int m_state, m_x, m_y, m_dx, m_dy, m_step, m_hits, m_hold;
  bit m_hit, m_miss;

  ball_motion dut (
    .clk        (clk),
    .reset      (rst_n),
    .frame_tick (frame_tick),
    .serve      (serve),
    .paddle_y   (paddle_y),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .miss       (miss),
    .hit        (hit),
    .playing    (playing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = 0; m_x = XC; m_y = YC; m_dx = 1; m_dy = 1;
    m_step = STEP; m_hits = 0; m_hold = 0; m_hit = 0; m_miss = 0;
  endtask

  task automatic step_model(input bit tick, input bit srv);
    int nx, ny;
    m_hit = 0;
    m_miss = 0;
    case (m_state)
      0: if (srv) m_state = 1;
      1: if (tick) begin
        nx = m_x + m_dx * m_step;
        ny = m_y + m_dy * m_step;
        if (m_dx < 0 && m_x >= FACE && nx < FACE &&
            m_y + 8 > int'(paddle_y) && m_y < int'(paddle_y) + 64) begin
          m_x = FACE; m_dx = 1; m_hit = 1; m_hits++;
`ifdef BALL_SPEEDUP_EN
          if (m_hits % 4 == 0 && m_step < STEP + 2) m_step++;
`endif
        end else if (m_dx < 0 && nx < 0) begin
          m_miss = 1; m_state = 2; m_hold = 0;
        end else if (m_dx > 0 && nx >= XMAX) begin
          m_x = XMAX; m_dx = -1;
        end else begin
          m_x = nx;
        end
        if (!m_miss) begin
          if (ny <= 0) begin m_y = 0; m_dy = 1; end
          else if (ny >= YMAX) begin m_y = YMAX; m_dy = -1; end
          else m_y = ny;
        end
      end
      2: if (tick) begin
        m_hold++;
        if (m_hold == HOLD) begin
          m_state = 0; m_x = XC; m_y = YC; m_dx = 1; m_dy = 1;
          m_step = STEP; m_hits = 0;
        end
      end
      default: m_state = 0;
    endcase
  endtask

  function automatic logic [22:0] exp_vec();
    return {10'(m_x), 10'(m_y), m_hit, m_miss, (m_state == 1)};
  endfunction

  // One clock: drive at negedge, model follows the edge, outputs settle by +1.
  task automatic clk_cycle(input bit tick, input bit srv);
    @(negedge clk);
    frame_tick = tick;
    serve      = srv;
    @(posedge clk);
    step_model(tick, srv);
    #1;
    if (miss === 1'b1) lives--;
  endtask

  // A tick after 0..2 quiet cycles; serve noise only outside idle.
  task automatic tick_once(input bit srv);
    int n;
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) clk_cycle(1'b0, (m_state != 0) ? 1'($urandom_range(0, 1)) : 1'b0);
    clk_cycle(1'b1, srv);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; frame_tick = 1'b0; serve = 1'b0; paddle_y = 10'd0;
    model_reset();
    #7;
    total++;
    if ({ball_x, ball_y, hit, miss, playing} !== {10'd316, 10'd236, 3'b000}) begin
      bad++;
      $display("FAIL reset: got x=%0d y=%0d h=%b m=%b p=%b want 316,236,0,0,0",
               ball_x, ball_y, hit, miss, playing);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_serve_with_tick();
    paddle_y = 10'd1000;
    clk_cycle(1'b1, 1'b1);
    total++;
    if (playing !== 1'b1 || ball_x !== 10'd316 || ball_y !== 10'd236) begin
      bad++;
      $display("FAIL serve_tick: got p=%b (%0d,%0d) want p=1 (316,236)", playing, ball_x, ball_y);
    end
    clk_cycle(1'b1, 1'b0);
    total++;
    if ({ball_x, ball_y, hit, miss, playing} !== {10'd318, 10'd238, 3'b001}) begin
      bad++;
      $display("FAIL first_tick: got (%0d,%0d) h=%b m=%b p=%b want (318,238) 0 0 1",
               ball_x, ball_y, hit, miss, playing);
    end
  endtask

  task automatic test_bottom_wall();
    bit found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      tick_once(1'($urandom_range(0, 1)));
      total++;
      if ({ball_x, ball_y, hit, miss, playing} !== exp_vec()) begin
        bad++;
        $display("FAIL wall_flight: got %h want %h", {ball_x, ball_y, hit, miss, playing}, exp_vec());
      end
      if (m_y == 470 && m_dy > 0) found = 1;
    end
    if (!found) begin
      bad++; total++;
      $display("FAIL wall_reach: y=470 going down not reached, got y=%0d", ball_y);
    end
    tick_once(1'b0);
    total++;
    if (ball_y !== 10'd472) begin
      bad++; $display("FAIL wall_clamp: got y=%0d want 472", ball_y);
    end
    tick_once(1'b0);
    total++;
    if (ball_y !== 10'd470) begin
      bad++; $display("FAIL wall_reflect: got y=%0d want 470", ball_y);
    end
  endtask

  task automatic test_paddle_hit();
    bit found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      paddle_y = 10'(m_y);
      tick_once(1'b0);
      total++;
      if ({ball_x, ball_y, hit, miss, playing} !== exp_vec()) begin
        bad++;
        $display("FAIL hit_flight: got %h want %h", {ball_x, ball_y, hit, miss, playing}, exp_vec());
      end
      if (m_hit) found = 1;
    end
    total++;
    if (!found || hit !== 1'b1 || miss !== 1'b0 || ball_x !== 10'd24) begin
      bad++;
      $display("FAIL paddle_hit: got hit=%b miss=%b x=%0d want 1 0 24", hit, miss, ball_x);
    end
    clk_cycle(1'b0, 1'b0);
    total++;
    if (hit !== 1'b0) begin
      bad++; $display("FAIL hit_width: got hit=%b one cycle later want 0", hit);
    end
  endtask

  task automatic test_speedup();
    bit   found = 0;
    logic [9:0] x0;
    for (int i = 0; i < 3000 && !found; i++) begin
      paddle_y = 10'(m_y);
      tick_once(1'b0);
      total++;
      if ({ball_x, ball_y, hit, miss, playing} !== exp_vec()) begin
        bad++;
        $display("FAIL speed_flight: got %h want %h", {ball_x, ball_y, hit, miss, playing}, exp_vec());
      end
      if (m_hits == 4) found = 1;
    end
    x0 = ball_x;
    tick_once(1'b0);
    total++;
    if (!found || int'(ball_x) - int'(x0) != STEP_AFTER4) begin
      bad++;
      $display("FAIL step_after_4_hits: got dx=%0d want %0d", int'(ball_x) - int'(x0), STEP_AFTER4);
    end
  endtask

  task automatic test_miss();
    bit found = 0;
    int lives0 = lives;
    for (int i = 0; i < 1500 && !found; i++) begin
      // Paddle moves onto the ball only once it is already behind the face.
      paddle_y = (m_x >= FACE) ? 10'd1000 : 10'(m_y);
      tick_once(1'b0);
      total++;
      if ({ball_x, ball_y, hit, miss, playing} !== exp_vec()) begin
        bad++;
        $display("FAIL miss_flight: got %h want %h", {ball_x, ball_y, hit, miss, playing}, exp_vec());
      end
      if (m_miss) found = 1;
    end
    total++;
    if (!found || miss !== 1'b1 || hit !== 1'b0 || playing !== 1'b0) begin
      bad++;
      $display("FAIL miss_pulse: got miss=%b hit=%b playing=%b want 1 0 0", miss, hit, playing);
    end
    for (int i = 1; i <= HOLD; i++) begin
      tick_once(1'($urandom_range(0, 1)));
      total++;
      if ({ball_x, ball_y, hit, miss, playing} !== exp_vec()) begin
        bad++;
        $display("FAIL hold %0d: got %h want %h", i, {ball_x, ball_y, hit, miss, playing}, exp_vec());
      end
    end
    total++;
    if (ball_x !== 10'd316 || ball_y !== 10'd236 || playing !== 1'b0 || m_state != 0) begin
      bad++;
      $display("FAIL recentre: got (%0d,%0d) p=%b want (316,236) p=0", ball_x, ball_y, playing);
    end
    total++;
    if (lives != lives0 - 1) begin
      bad++; $display("FAIL lives: got %0d want %0d", lives, lives0 - 1);
    end
    clk_cycle(1'b0, 1'b1);
    clk_cycle(1'b1, 1'b0);
    total++;
    if ({ball_x, ball_y, playing} !== {10'd318, 10'd238, 1'b1}) begin
      bad++;
      $display("FAIL reserve: got (%0d,%0d) p=%b want (318,238) p=1", ball_x, ball_y, playing);
    end
  endtask

  task automatic test_reset_midflight();
    bit found = 0;
    int lives0 = lives;
    paddle_y = 10'd1000;
    for (int i = 0; i < 400 && !found; i++) begin
      tick_once(1'b0);
      if (m_x >= 500) found = 1;
    end
    total++;
    if (!found || {ball_x, ball_y} !== {10'(m_x), 10'(m_y)}) begin
      bad++;
      $display("FAIL pre_reset: got (%0d,%0d) want (%0d,%0d)", ball_x, ball_y, m_x, m_y);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if ({ball_x, ball_y, hit, miss, playing} !== {10'd316, 10'd236, 3'b000}) begin
      bad++;
      $display("FAIL midflight_reset: got (%0d,%0d) h=%b m=%b p=%b want (316,236) 0 0 0",
               ball_x, ball_y, hit, miss, playing);
    end
    @(negedge clk);
    rst_n = 1'b1;
    clk_cycle(1'b1, 1'b0);
    total++;
    if (lives != lives0 || playing !== 1'b0 || ball_x !== 10'd316) begin
      bad++;
      $display("FAIL after_reset: lives=%0d p=%b x=%0d want %0d 0 316", lives, playing, ball_x, lives0);
    end
  endtask

  task automatic test_random();
    int py;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        py = m_y - int'($urandom_range(0, 40));
        paddle_y = (py < 0) ? 10'd0 : 10'(py);
      end else begin
        paddle_y = 10'($urandom_range(0, 1023));
      end
      clk_cycle(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
      total++;
      if ({ball_x, ball_y, hit, miss, playing} !== exp_vec()) begin
        bad++;
        $display("FAIL random cyc %0d: got %h want %h", i, {ball_x, ball_y, hit, miss, playing},
                 exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_serve_with_tick();
    test_bottom_wall();
    test_paddle_hit();
    test_speedup();
    test_miss();
    test_reset_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
